uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RxD,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        overrun
);
  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
  logic                  par_ok;
`endif

  logic                 rx_p0, rx_p1, rx_p2;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 wr_pend;
  logic                 tick, fall, mid;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 do_rd, do_wr;

  assign tick = (div_cnt == DIV_W'(DIV - 1));
  assign fall = rx_p2 & ~rx_p1;
  assign mid  = tick & (tick_cnt == 4'd15);

  // Stage p0/p1: metastability synchroniser; p2 holds the previous level for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= RxD;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if ((state == S_IDLE && fall) || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        S_IDLE:
          if (fall) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        S_START:
          // Re-phase the tick counter so every later sample lands mid-bit
          if (tick && tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_p1 ? S_IDLE : S_DATA;
          end
        S_DATA:
          if (mid) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (mid) state <= S_STOP;
`endif
        S_STOP:
          if (mid) begin
            if (!rx_p1) begin
              frame_err <= 1'b1;
              state     <= S_WAIT;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (par_ok) wr_pend <= 1'b1;
              else frame_err <= 1'b1;
`else
              wr_pend <= 1'b1;
`endif
              state <= S_IDLE;
            end
          end
        S_WAIT:
          if (rx_p1) state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_pend & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (state == S_DATA && mid) shreg <= {rx_p1, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
    if (state == S_PARITY && mid) par_ok <= ~((^shreg) ^ rx_p1);
`endif
    if (do_wr) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr_pend && full && !do_rd) overrun <= 1'b1;
      count <= count + (PTR_W + 1)'(do_wr) - (PTR_W + 1)'(do_rd);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue model of the receive buffer, monitor pops on reads.
// Build with UART_RX_PARITY_EN defined to exercise the parity frames as well.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_HZ     = 640000;
  localparam int BAUD       = 10000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT        = 16 * (CLK_HZ / (BAUD * 16));
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 RxD = 1'b1;
  logic                 rd_en = 1'b0;
  logic [DATA_BITS-1:0] dout;
  logic                 empty, full, frame_err, overrun;
  logic [CW-1:0]        count;

  int tests = 0;
  int fails = 0;
  logic [DATA_BITS-1:0] model_q[$];
  bit ovr_exp = 1'b0;
  int ferr_exp = 0;
  int ferr_seen = 0;
  int wr_idx = -1;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .rd_en(rd_en), .dout(dout),
    .empty(empty), .full(full), .count(count), .frame_err(frame_err), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read is compared against the head of the model queue
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err === 1'b1) ferr_seen++;
      if (rd_en && empty === 1'b0) begin
        if (model_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: dout=0x%0h with nothing expected", dout);
        end else begin
          check("pop_data", dout, model_q.pop_front());
        end
      end
    end
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      cyc(1);
    end
    rd_en = 1'b0;
  endtask

  task automatic model_write(input logic [DATA_BITS-1:0] d, input bit simul_rd);
    if (model_q.size() < FIFO_DEPTH || simul_rd) model_q.push_back(d);
    else ovr_exp = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    model_q.delete();
    ovr_exp = 1'b0;
    cyc(1);
  endtask

  // rd_at >= 0 pulses rd_en on that cycle of the stop bit (timed to coincide with the write)
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop, input bit pflip,
                            input int rd_at);
    bit   good;
    logic was_empty;
    RxD = 1'b0;
    cyc(BIT);
    for (int i = 0; i < DATA_BITS; i++) begin
      RxD = d[i];
      cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    RxD = (^d) ^ pflip;
    cyc(BIT);
`endif
    good = stop && !pflip;
    if (good) model_write(d, rd_at >= 0);
    else ferr_exp++;
    RxD = stop;
    for (int i = 0; i < BIT; i++) begin
      if (rd_at >= 0) rd_en = (i == rd_at);
      was_empty = empty;
      cyc(1);
      if (was_empty === 1'b1 && empty === 1'b0 && wr_idx < 0) wr_idx = i;
    end
    if (rd_at >= 0) rd_en = 1'b0;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_dout", dout, 0);

    send_frame(8'h55, 1, 0, -1);
    check("f55_dout", dout, 8'h55);
    check("f55_empty", empty, 0);
    check("f55_count", count, 1);
    check("f55_ferr", ferr_seen, 0);
    check("wr_seen", (wr_idx >= 0), 1);
    pop_n(1);
    check("f55_drained", empty, 1);

    // Read held high across a write into an empty buffer
    rd_en = 1'b1;
    send_frame(8'h5A, 1, 0, -1);
    cyc(3);
    rd_en = 1'b0;
    check("wr_rd_empty_count", count, 0);
    check("wr_rd_empty_flag", empty, 1);

    for (int k = 0; k <= 16; k++) begin
      send_frame(DATA_BITS'(k), 1, 0, -1);
      if (k == 15) begin
        check("fill_full", full, 1);
        check("fill_no_ovr", overrun, 0);
      end
    end
    check("ovr_set", overrun, 1);
    check("ovr_model", overrun, ovr_exp);
    check("ovr_count", count, FIFO_DEPTH);
    pop_n(FIFO_DEPTH);
    check("ovr_drained", empty, 1);
    check("ovr_sticky", overrun, 1);

    do_reset();
    check("rst2_overrun", overrun, 0);
    check("rst2_count", count, 0);
    for (int k = 0; k < FIFO_DEPTH; k++) send_frame(DATA_BITS'($urandom), 1, 0, -1);
    check("refill_full", full, 1);
    send_frame(8'hC7, 1, 0, wr_idx);
    cyc(2);
    check("simul_count", count, FIFO_DEPTH);
    check("simul_full", full, 1);
    check("simul_no_ovr", overrun, 0);
    pop_n(FIFO_DEPTH);
    check("simul_drained", empty, 1);

    RxD = 1'b0;
    cyc(BIT / 2 - 12);
    RxD = 1'b1;
    cyc(3 * BIT);
    check("glitch_empty", empty, 1);
    check("glitch_ferr", ferr_seen, ferr_exp);

    send_frame(8'hA3, 0, 0, -1);
    cyc(30 * BIT);
    check("break_ferr", ferr_seen, ferr_exp);
    check("break_empty", empty, 1);
    RxD = 1'b1;
    cyc(BIT);
    send_frame(8'h3C, 1, 0, -1);
    check("after_break_dout", dout, 8'h3C);
    check("after_break_ferr", ferr_seen, ferr_exp);
    pop_n(1);

    RxD = 1'b0;
    cyc(BIT);
    RxD = 1'b1;
    cyc(4 * BIT + BIT / 2);
    do_reset();
    cyc(5 * BIT);
    check("midrst_empty", empty, 1);
    check("midrst_count", count, 0);
    check("midrst_ferr", ferr_seen, ferr_exp);
    send_frame(8'h81, 1, 0, -1);
    check("midrst_next", dout, 8'h81);
    pop_n(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 1, -1);
    check("par_bad_ferr", ferr_seen, ferr_exp);
    check("par_bad_empty", empty, 1);
    send_frame(8'h07, 1, 0, -1);
    check("par_good_dout", dout, 8'h07);
    pop_n(1);
`endif

    for (int n = 0; n < 25; n++) begin
      logic [DATA_BITS-1:0] d;
      bit stop, pflip;
      d = DATA_BITS'($urandom);
      stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pflip = stop && ($urandom_range(0, 5) == 0);
`else
      pflip = 1'b0;
`endif
      send_frame(d, stop, pflip, -1);
      if (!stop) begin
        RxD = 1'b1;
        cyc(BIT);
      end
      cyc($urandom_range(2, 20));
      pop_n($urandom_range(0, model_q.size() + 1));
      check("rnd_count", count, model_q.size());
      check("rnd_overrun", overrun, ovr_exp);
      check("rnd_ferr", ferr_seen, ferr_exp);
    end
    pop_n(model_q.size());
    check("final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
